// File: rtl/mat_job_if.sv
// Requester, datapath and response signals of the matrix job scheduler.
// The scheduler takes the slave side; the requester/datapath environment takes the master side.
interface mat_job_if #(
  parameter int WIDTH = 8,
  parameter int RES_W = 64,
  parameter int CNT_W = 16
);
  logic [1:0]             req_valid;
  logic [2*4*WIDTH-1:0]   req_a;
  logic [2*4*WIDTH-1:0]   req_b;
  logic [1:0]             req_ready;
  logic [4*WIDTH-1:0]     mat_a;
  logic [4*WIDTH-1:0]     mat_b;
  logic [RES_W-1:0]       mat_res;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [RES_W-1:0]       rsp_data;
  logic                   busy;
  logic [CNT_W-1:0]       jobs_done;

  modport slave (
    input  req_valid, req_a, req_b, mat_res, rsp_ready,
    output req_ready, mat_a, mat_b, rsp_valid, rsp_id, rsp_data, busy, jobs_done
  );
  modport master (
    output req_valid, req_a, req_b, mat_res, rsp_ready,
    input  req_ready, mat_a, mat_b, rsp_valid, rsp_id, rsp_data, busy, jobs_done
  );
endinterface

// File: rtl/mat_job_scheduler.sv
// Round-robin scheduler sharing one fixed-latency 2x2 matrix datapath between two requesters.
// One job in flight: accept, wait LAT cycles, hold the tagged result until the consumer takes it.
module mat_job_scheduler #(
  parameter int WIDTH = 8,
  parameter int RES_W = 64,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  mat_job_if.slave bus
);
  localparam int OPW = 4*WIDTH;
  localparam int LCW = ($clog2(LAT) > 0) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic             id;
    logic [RES_W-1:0] data;
  } rsp_t;

  state_t              state;
  logic                ptr;
  logic [LCW-1:0]      cnt;
  rsp_t                rsp;
  logic                rsp_valid;
  logic [OPW-1:0]      mat_a, mat_b;
  logic [CNT_W-1:0]    jobs_done;
  logic [1:0][OPW-1:0] ops_a, ops_b;
  logic                grant, grant_vld;

  assign ops_a = bus.req_a;
  assign ops_b = bus.req_b;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_vld = |bus.req_valid;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ptr;
      default: grant = 1'b0;
    endcase
  end

  assign bus.req_ready = (state == IDLE && grant_vld) ? (2'b01 << grant) : 2'b00;
  assign bus.busy      = (state != IDLE);
  assign bus.mat_a     = mat_a;
  assign bus.mat_b     = mat_b;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp.id;
  assign bus.rsp_data  = rsp.data;
  assign bus.jobs_done = jobs_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      rsp       <= '0;
      rsp_valid <= 1'b0;
      mat_a     <= '0;
      mat_b     <= '0;
      jobs_done <= '0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          mat_a  <= ops_a[grant];
          mat_b  <= ops_b[grant];
          rsp.id <= grant;
          ptr    <= ~grant;
          cnt    <= LCW'(LAT-1);
          state  <= WAIT;
        end
        // Operands settle into the datapath on the accept edge; sample LAT edges later.
        WAIT: if (cnt == '0) begin
          rsp.data  <= bus.mat_res;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
          jobs_done <= jobs_done + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_job_scheduler.sv
// Bench for mat_job_scheduler: a stand-in datapath ((A*B+C)*D+E with C=all 3s, D=I, E=0),
// a transaction-level model checked every cycle, directed scenarios and a random phase.
module tb_mat_job_scheduler;
  localparam int WIDTH = 8, RES_W = 64, LAT = 2, OPW = 4*WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mat_job_if #(.WIDTH(WIDTH), .RES_W(RES_W), .CNT_W(16)) bus ();
  mat_job_if #(.WIDTH(WIDTH), .RES_W(RES_W), .CNT_W(4))  bus4 ();

  mat_job_scheduler #(.WIDTH(WIDTH), .RES_W(RES_W), .LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  mat_job_scheduler #(.WIDTH(WIDTH), .RES_W(RES_W), .LAT(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave));

  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_a     = bus.req_a;
  assign bus4.req_b     = bus.req_b;
  assign bus4.rsp_ready = bus.rsp_ready;

  // Stand-in datapath: element (i,j) = sum_k A[i][k]*B[k][j] + 3, 8-bit elements in the low word.
  function automatic logic [RES_W-1:0] dp(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [WIDTH-1:0] ea [4];
    logic [WIDTH-1:0] eb [4];
    logic [WIDTH-1:0] r  [4];
    logic [RES_W-1:0] res;
    for (int k = 0; k < 4; k++) begin
      ea[k] = a[OPW-1-k*WIDTH -: WIDTH];
      eb[k] = b[OPW-1-k*WIDTH -: WIDTH];
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[2*i+j] = WIDTH'(ea[2*i]*eb[j] + ea[2*i+1]*eb[2+j] + 3);
    res = '0;
    res[31:0] = {r[0], r[1], r[2], r[3]};
    return res;
  endfunction

  // LAT-1 register stages after the combinational math: valid exactly LAT edges after a change.
  logic [RES_W-1:0] dp_q = '0, dp4_q = '0;
  always @(posedge clk) begin
    dp_q  <= dp(bus.mat_a, bus.mat_b);
    dp4_q <= dp(bus4.mat_a, bus4.mat_b);
  end
  assign bus.mat_res  = dp_q;
  assign bus4.mat_res = dp4_q;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pick(input logic [1:0] v, input logic p);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return p;
  endfunction

  // Transaction model: a job is outstanding from its accept edge until its response is taken.
  logic           m_out = 0, m_id = 0, m_ptr = 0;
  int             m_age = 0, m_done = 0;
  logic [OPW-1:0] m_a = '0, m_b = '0;
  logic [RES_W-1:0] m_rdata = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_out = 0; m_id = 0; m_ptr = 0; m_age = 0; m_done = 0;
      m_a = '0; m_b = '0; m_rdata = '0;
    end else if (!m_out) begin
      if (bus.req_valid != 2'b00) begin
        m_id  = pick(bus.req_valid, m_ptr);
        m_ptr = !m_id;
        m_a   = bus.req_a[m_id*OPW +: OPW];
        m_b   = bus.req_b[m_id*OPW +: OPW];
        m_out = 1; m_age = 0;
      end
    end else if (m_age >= LAT && bus.rsp_ready) begin
      m_out = 0; m_done++;
    end else begin
      m_age++;
      if (m_age == LAT) m_rdata = dp(m_a, m_b);
    end
  end

  int cyc = 0;
  int acc_id [$];
  int acc_cyc[$];
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset && (bus.req_ready & bus.req_valid) != 2'b00) begin
      acc_id.push_back(int'(bus.req_ready[1]));
      acc_cyc.push_back(cyc);
    end
  end

  initial forever begin
    logic [1:0] er;
    @(negedge clk);
    er = (!m_out && bus.req_valid != 2'b00) ? (2'b01 << pick(bus.req_valid, m_ptr)) : 2'b00;
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, m_out && m_age >= LAT);
    chk("rsp_id",    bus.rsp_id, m_id);
    chk("rsp_data",  bus.rsp_data, m_rdata);
    chk("busy",      bus.busy, m_out);
    chk("mat_a",     bus.mat_a, m_a);
    chk("mat_b",     bus.mat_b, m_b);
    chk("jobs_done", bus.jobs_done, 64'(m_done % 65536));
    chk("jobs4",     bus4.jobs_done, 64'(m_done % 16));
    chk("rsp_valid4", bus4.rsp_valid, m_out && m_age >= LAT);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int t = 0;
    while (acc_id.size() < n && t < 100) begin step(); t++; end
    if (acc_id.size() < n) chk({nm, "_accept_timeout"}, 64'(acc_id.size()), 64'(n));
  endtask

  task automatic pulse_reset();
    #2 reset = 1;
    step();
    reset = 0;
    step();
  endtask

  initial begin
    int n;
    logic [OPW-1:0] a1, b1;
    logic [RES_W-1:0] e1;
    reset = 1;
    bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    #12;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mat_a",     bus.mat_a, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_jobs",      bus.jobs_done, 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    @(posedge clk); #1 reset = 0;
    step();

    // Single job from requester 0; identity B makes the result A + 3 per element.
    bus.req_a = {32'h0, 32'h01020304};
    bus.req_b = {32'h0, 32'h01000001};
    bus.req_valid = 2'b01;
    #1 chk("t1_ready_same_cycle", bus.req_ready, 2'b01);
    @(posedge clk); #1 bus.req_valid = 2'b00;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    chk("t1_latency", n, LAT);
    chk("t1_rsp_data", bus.rsp_data, 64'h0000_0000_0405_0607);
    chk("t1_model_data", m_rdata, 64'h0000_0000_0405_0607);
    chk("t1_rsp_id", bus.rsp_id, 0);
    step();
    chk("t1_jobs_done", bus.jobs_done, 1);

    // Simultaneous requests right after reset: requester 0 first.
    pulse_reset();
    acc_id.delete(); acc_cyc.delete();
    bus.req_a = {$urandom, $urandom}; bus.req_b = {$urandom, $urandom};
    bus.req_valid = 2'b11;
    wait_acc(1, "t2a");
    bus.req_valid = 2'b10;
    wait_acc(2, "t2b");
    bus.req_valid = 2'b00;
    if (acc_id.size() >= 2) begin
      chk("t2_first_id", acc_id[0], 0);
      chk("t2_second_id", acc_id[1], 1);
    end
    repeat (6) step();

    // Consumer stalls in RESP while both requesters wait.
    a1 = 32'h05060708; b1 = 32'h02010103; e1 = dp(a1, b1);
    acc_id.delete(); acc_cyc.delete();
    bus.rsp_ready = 1'b0;
    bus.req_a = {a1, 32'h0}; bus.req_b = {b1, 32'h0};
    bus.req_valid = 2'b10;
    wait_acc(1, "t3");
    bus.req_valid = 2'b11;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    repeat (5) begin
      chk("t3_hold_valid", bus.rsp_valid, 1);
      chk("t3_hold_id",    bus.rsp_id, 1);
      chk("t3_hold_data",  bus.rsp_data, e1);
      chk("t3_hold_mat_a", bus.mat_a, a1);
      chk("t3_hold_mat_b", bus.mat_b, b1);
      chk("t3_no_ready",   bus.req_ready, 2'b00);
      chk("t3_busy",       bus.busy, 1);
      step();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (3) step();

    // Both held valid: alternating grants, one accept every LAT+2 cycles.
    acc_id.delete(); acc_cyc.delete();
    bus.req_valid = 2'b11;
    wait_acc(4, "t4");
    bus.req_valid = 2'b00;
    for (int i = 1; i < 4 && i < acc_id.size(); i++) begin
      chk("t4_alternate", acc_id[i], 1 - acc_id[i-1]);
      chk("t4_spacing", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
    end
    repeat (6) step();

    // Reset mid-WAIT: outputs clear without a clock edge, the job is dropped.
    acc_id.delete(); acc_cyc.delete();
    bus.req_a = {$urandom, $urandom}; bus.req_b = {$urandom, $urandom};
    bus.req_valid = 2'b01;
    wait_acc(1, "t5");
    bus.req_valid = 2'b00;
    #2 reset = 1;
    #1;
    chk("t5_rst_mat_a",    bus.mat_a, 0);
    chk("t5_rst_mat_b",    bus.mat_b, 0);
    chk("t5_rst_busy",     bus.busy, 0);
    chk("t5_rst_rsp_id",   bus.rsp_id, 0);
    chk("t5_rst_jobs",     bus.jobs_done, 0);
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    step();
    reset = 0;
    repeat (6) step();
    chk("t5_no_rsp", bus.rsp_valid, 0);
    chk("t5_jobs_zero", bus.jobs_done, 0);

    // Sixteen jobs from requester 1: the 4-bit counter wraps to zero.
    acc_id.delete(); acc_cyc.delete();
    bus.req_valid = 2'b10;
    wait_acc(16, "t6");
    bus.req_valid = 2'b00;
    repeat (5) step();
    chk("t6_jobs4_wrap", bus4.jobs_done, 0);
    chk("t6_jobs16", bus.jobs_done, 16);
    for (int i = 0; i < acc_id.size(); i++) chk("t6_id", acc_id[i], 1);

    // Random traffic against the model.
    repeat (400) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a = {$urandom, $urandom};
      bus.req_b = {$urandom, $urandom};
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
